// File: rtl/gfp8_nv_dot_sched_if.sv
// Command, operand-issue, engine-return and result signals of the GFP8 NV dot sequencer.
interface gfp8_nv_dot_sched_if #(
  parameter int unsigned NV_CNT_W = 8
);
  logic                i_cmd_valid;
  logic                o_cmd_ready;
  logic [NV_CNT_W-1:0] i_cmd_nv_count;
  logic                i_nv_avail;
  logic [NV_CNT_W-1:0] o_nv_idx;
  logic                o_dot_input_valid;
  logic signed [31:0]  i_dot_mantissa;
  logic signed [7:0]   i_dot_exponent;
  logic                i_abort;
  logic                o_result_valid;
  logic                i_result_ready;
  logic signed [31:0]  o_result_mantissa;
  logic signed [7:0]   o_result_exponent;
  logic                o_sat;
  logic                o_busy;

  modport slave (
    input  i_cmd_valid, i_cmd_nv_count, i_nv_avail, i_dot_mantissa, i_dot_exponent, i_abort,
           i_result_ready,
    output o_cmd_ready, o_nv_idx, o_dot_input_valid, o_result_valid, o_result_mantissa,
           o_result_exponent, o_sat, o_busy
  );

  modport master (
    output i_cmd_valid, i_cmd_nv_count, i_nv_avail, i_dot_mantissa, i_dot_exponent, i_abort,
           i_result_ready,
    input  o_cmd_ready, o_nv_idx, o_dot_input_valid, o_result_valid, o_result_mantissa,
           o_result_exponent, o_sat, o_busy
  );
endinterface

// File: rtl/gfp8_nv_dot_sched.sv
// GFP8 native-vector dot sequencer: issues NVs to the engine, tracks returns through the fixed
// engine latency and accumulates the exponent-aligned partials into one result.
module gfp8_nv_dot_sched #(
  parameter int unsigned DOT_LATENCY = 5,
  parameter int unsigned NV_CNT_W    = 8
) (
  input logic                i_clk,
  input logic                i_reset_n,
  gfp8_nv_dot_sched_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  localparam logic [NV_CNT_W-1:0] CntOne = NV_CNT_W'(1);

  state_e                 state_q, state_d;
  logic [NV_CNT_W-1:0]    cnt_q, idx_q, ret_q;
  logic [DOT_LATENCY-1:0] tag_q;
  logic signed [31:0]     acc_man_q;
  logic signed [7:0]      acc_exp_q;
  logic                   sat_q, first_q, valid_q;

  logic               issue, pop, last_issue, last_ret, cmd_take;
  logic signed [31:0] ret_man, acc_al, ret_al, sum_sat;
  logic signed [7:0]  ret_exp, e_max;
  logic [8:0]         acc_ext, ret_ext, sh_amt;
  logic [32:0]        sum;
  logic               sum_ovf;

  assign ret_man    = bus.i_dot_mantissa;
  assign ret_exp    = bus.i_dot_exponent;
  assign cmd_take   = (state_q == StIdle) && bus.i_cmd_valid;
  // Tags only exist while issuing or draining; abort clears them so stale returns are dropped.
  assign pop        = tag_q[DOT_LATENCY-1] && ((state_q == StIssue) || (state_q == StDrain));
  assign last_issue = issue && (idx_q == cnt_q - CntOne);
  assign last_ret   = pop && (ret_q + CntOne == cnt_q);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.i_cmd_valid) state_d = (bus.i_cmd_nv_count == '0) ? StDone : StIssue;
      StIssue: if (last_issue) state_d = StDrain;
      StDrain: if (last_ret) state_d = StDone;
      StDone:  if (bus.i_result_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (bus.i_abort) state_d = StIdle;
  end

  always_comb begin
    issue                 = (state_q == StIssue) && bus.i_nv_avail;
    bus.o_dot_input_valid = issue;
    bus.o_cmd_ready       = (state_q == StIdle);
    bus.o_busy            = (state_q != StIdle);
  end

  // Align both operands to the larger exponent; shifts past 31 flush the operand to zero.
  always_comb begin
    acc_ext = {acc_exp_q[7], acc_exp_q};
    ret_ext = {ret_exp[7], ret_exp};
    acc_al  = acc_man_q;
    ret_al  = ret_man;
    if ($signed(acc_ext) < $signed(ret_ext)) begin
      e_max  = ret_exp;
      sh_amt = ret_ext - acc_ext;
      if (sh_amt > 9'd31) acc_al = '0;
      else                acc_al = acc_man_q >>> sh_amt[4:0];
    end else begin
      e_max  = acc_exp_q;
      sh_amt = acc_ext - ret_ext;
      if (sh_amt > 9'd31) ret_al = '0;
      else                ret_al = ret_man >>> sh_amt[4:0];
    end
    sum     = {acc_al[31], acc_al} + {ret_al[31], ret_al};
    sum_ovf = sum[32] ^ sum[31];
    if (!sum_ovf)     sum_sat = sum[31:0];
    else if (sum[32]) sum_sat = 32'sh8000_0000;
    else              sum_sat = 32'sh7FFF_FFFF;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      ret_q     <= '0;
      tag_q     <= '0;
      acc_man_q <= '0;
      acc_exp_q <= '0;
      sat_q     <= 1'b0;
      first_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else if (bus.i_abort) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      ret_q     <= '0;
      tag_q     <= '0;
      acc_man_q <= '0;
      acc_exp_q <= '0;
      sat_q     <= 1'b0;
      first_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= (state_d == StDone);
      tag_q   <= (tag_q << 1) | DOT_LATENCY'(issue);
      if (cmd_take) begin
        cnt_q     <= bus.i_cmd_nv_count;
        idx_q     <= '0;
        ret_q     <= '0;
        acc_man_q <= '0;
        acc_exp_q <= '0;
        sat_q     <= 1'b0;
        first_q   <= 1'b1;
      end
      if (issue) idx_q <= idx_q + CntOne;
      if (pop) begin
        ret_q   <= ret_q + CntOne;
        first_q <= 1'b0;
        if (first_q) begin
          acc_man_q <= ret_man;
          acc_exp_q <= ret_exp;
        end else begin
          acc_man_q <= sum_sat;
          acc_exp_q <= e_max;
          if (sum_ovf) sat_q <= 1'b1;
        end
      end
    end
  end

  assign bus.o_nv_idx          = idx_q;
  assign bus.o_result_valid    = valid_q;
  assign bus.o_result_mantissa = acc_man_q;
  assign bus.o_result_exponent = acc_exp_q;
  assign bus.o_sat             = sat_q;

endmodule

// File: tb/tb_gfp8_nv_dot_sched.sv
// Bench for gfp8_nv_dot_sched: vector table through a latency-accurate engine model, scoreboarded
// results, plus abort and asynchronous-reset sequences.
module tb_gfp8_nv_dot_sched;
  localparam int unsigned DL = 5;
  localparam int unsigned NW = 8;

  typedef struct packed {
    logic [7:0]       count;
    logic [3:0][31:0] man;
    logic [3:0][7:0]  ex;
    logic [15:0]      pat;
    logic [7:0]       pat_len;
    logic [31:0]      r_man;
    logic [7:0]       r_exp;
    logic             r_sat;
    logic [7:0]       lat;
    logic [7:0]       hold;
  } vec_t;

  typedef struct packed {
    logic [31:0] man;
    logic [7:0]  ex;
    logic        sat;
  } res_t;

  typedef struct packed {
    int          due;
    logic [31:0] man;
    logic [7:0]  ex;
  } ret_t;

  logic        clk;
  logic        rst_n;
  int          cyc = 0;
  int          n_checks;
  int          n_pass;
  int          issue_cnt;
  logic [31:0] tbl_man[4];
  logic [7:0]  tbl_exp[4];
  res_t        sb_q[$];
  ret_t        eng_q[$];
  vec_t        vecs[11];

  gfp8_nv_dot_sched_if #(.NV_CNT_W(NW)) bus ();

  gfp8_nv_dot_sched #(
    .DOT_LATENCY(DL),
    .NV_CNT_W   (NW)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Engine model: every issue seen in cycle c returns its table entry in cycle c+DL.
  always @(negedge clk) begin
    ret_t e;
    if (rst_n && bus.o_dot_input_valid) begin
      check("nv_idx order", bus.o_nv_idx, issue_cnt);
      e.due = cyc + DL;
      e.man = tbl_man[bus.o_nv_idx[1:0]];
      e.ex  = tbl_exp[bus.o_nv_idx[1:0]];
      eng_q.push_back(e);
      issue_cnt++;
    end
  end

  // Non-return cycles carry junk so that untagged data would corrupt the result.
  always @(posedge clk) begin
    ret_t e;
    #1;
    if (eng_q.size() > 0 && eng_q[0].due == cyc) begin
      e = eng_q.pop_front();
      bus.i_dot_mantissa = e.man;
      bus.i_dot_exponent = e.ex;
    end else begin
      bus.i_dot_mantissa = $urandom;
      bus.i_dot_exponent = 8'($urandom);
    end
  end

  function automatic vec_t mk(int cnt, int m0, int e0, int m1, int e1, int m2, int e2, int m3,
                              int e3, int rm, int re, bit rs, int lat, int hold, int pat,
                              int plen);
    vec_t v;
    v.count   = 8'(cnt);
    v.man[0]  = m0;
    v.man[1]  = m1;
    v.man[2]  = m2;
    v.man[3]  = m3;
    v.ex[0]   = 8'(e0);
    v.ex[1]   = 8'(e1);
    v.ex[2]   = 8'(e2);
    v.ex[3]   = 8'(e3);
    v.r_man   = rm;
    v.r_exp   = 8'(re);
    v.r_sat   = rs;
    v.lat     = 8'(lat);
    v.hold    = 8'(hold);
    v.pat     = 16'(pat);
    v.pat_len = 8'(plen);
    return v;
  endfunction

  task automatic check_reset(input string name);
    check({name, " cmd_ready"}, bus.o_cmd_ready, 1);
    check({name, " busy"}, bus.o_busy, 0);
    check({name, " dot_valid"}, bus.o_dot_input_valid, 0);
    check({name, " result_valid"}, bus.o_result_valid, 0);
    check({name, " nv_idx"}, bus.o_nv_idx, 0);
    check({name, " man"}, bus.o_result_mantissa, 0);
    check({name, " exp"}, bus.o_result_exponent, 0);
    check({name, " sat"}, bus.o_sat, 0);
  endtask

  task automatic run_cmd(input string name, input vec_t v);
    int   a;
    int   k;
    bit   got;
    res_t r;
    @(posedge clk); #1;
    k = 0;
    while (!bus.o_cmd_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, " cmd_ready"}, bus.o_cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tbl_man[i] = v.man[i];
      tbl_exp[i] = v.ex[i];
    end
    issue_cnt = 0;
    r.man = v.r_man;
    r.ex  = v.r_exp;
    r.sat = v.r_sat;
    sb_q.push_back(r);
    bus.i_cmd_valid    = 1'b1;
    bus.i_cmd_nv_count = v.count;
    bus.i_nv_avail     = 1'b0;
    bus.i_result_ready = (v.hold == 8'd0);
    a = cyc;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    got = 1'b0;
    for (k = 0; k < 200 && !got; k++) begin
      bus.i_nv_avail = (k < int'(v.pat_len)) ? v.pat[k[3:0]] : 1'b1;
      @(negedge clk);
      if (bus.o_result_valid) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      check({name, " result timeout"}, 0, 1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      bus.i_abort = 1'b1;
      @(posedge clk); #1;
      bus.i_abort = 1'b0;
      return;
    end
    if (v.lat != 8'd0) check({name, " latency"}, cyc - a, v.lat);
    for (int h = 0; h < int'(v.hold); h++) begin
      check({name, " hold valid"}, bus.o_result_valid, 1);
      check({name, " hold cmd_ready"}, bus.o_cmd_ready, 0);
      check({name, " hold man"}, bus.o_result_mantissa, $signed(v.r_man));
      @(posedge clk); #1;
      @(negedge clk);
    end
    bus.i_result_ready = 1'b1;
    check({name, " valid"}, bus.o_result_valid, 1);
    if (sb_q.size() > 0) begin
      r = sb_q.pop_front();
      check({name, " man"}, bus.o_result_mantissa, $signed(r.man));
      check({name, " exp"}, bus.o_result_exponent, $signed(r.ex));
      check({name, " sat"}, bus.o_sat, r.sat);
    end else begin
      check({name, " scoreboard empty"}, 0, 1);
    end
    check({name, " issue count"}, issue_cnt, v.count);
    @(posedge clk); #1;
    bus.i_result_ready = 1'b0;
    bus.i_nv_avail     = 1'b0;
    @(negedge clk);
    check({name, " idle cmd_ready"}, bus.o_cmd_ready, 1);
    check({name, " valid drop"}, bus.o_result_valid, 0);
  endtask

  initial begin
    n_checks           = 0;
    n_pass             = 0;
    issue_cnt          = 0;
    rst_n              = 1'b1;
    bus.i_cmd_valid    = 1'b0;
    bus.i_cmd_nv_count = '0;
    bus.i_nv_avail     = 1'b0;
    bus.i_abort        = 1'b0;
    bus.i_result_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tbl_man[i] = '0;
      tbl_exp[i] = '0;
    end

    //           cnt  m0            e0  m1     e1  m2    e2  m3 e3  r_man          r_e r_s lat  hold pat  plen
    vecs[0]  = mk(1, 100,           3,  0,     0,  0,    0,  0, 0,  100,           3,  0,  7,   0,   0,    0);
    vecs[1]  = mk(2, 64,            5,  64,    3,  0,    0,  0, 0,  80,            5,  0,  8,   0,   0,    0);
    vecs[2]  = mk(2, 8,             2,  -7,    0,  0,    0,  0, 0,  6,             2,  0,  8,   0,   0,    0);
    vecs[3]  = mk(2, 32'h7FFFFFF0,  0,  32'h20, 0, 0,    0,  0, 0,  32'h7FFFFFFF,  0,  1,  8,   0,   0,    0);
    vecs[4]  = mk(2, 1000,          40, 12345, 0,  0,    0,  0, 0,  1000,          40, 0,  8,   0,   0,    0);
    vecs[5]  = mk(4, 1,             0,  2,     0,  3,    0,  4, 0,  10,            0,  0,  13,  10,  'h59, 7);
    vecs[6]  = mk(0, 0,             0,  0,     0,  0,    0,  0, 0,  0,             0,  0,  1,   0,   0,    0);
    vecs[7]  = mk(3, -5,            1,  3,     1,  -100, -2, 0, 0,  -15,           1,  0,  9,   0,   0,    0);
    vecs[8]  = mk(2, 32'sh80000000, 0,  -1,    0,  0,    0,  0, 0,  32'sh80000000, 0,  1,  8,   0,   0,    0);
    vecs[9]  = mk(2, -1,            0,  5,     32, 0,    0,  0, 0,  5,             32, 0,  8,   0,   0,    0);
    vecs[10] = mk(1, 1,             -128, 0,   0,  0,    0,  0, 0,  1,             -128, 0, 7,  0,   0,    0);

    #1 rst_n = 1'b0;
    #1 check_reset("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset("after reset");

    for (int i = 0; i < 11; i++) run_cmd($sformatf("vec%0d", i), vecs[i]);

    // Abort while draining a count-3 command; its late returns must not leak into the next one.
    @(posedge clk); #1;
    tbl_man[0] = 10; tbl_man[1] = 20; tbl_man[2] = 30;
    tbl_exp[0] = 0;  tbl_exp[1] = 0;  tbl_exp[2] = 0;
    issue_cnt          = 0;
    bus.i_cmd_valid    = 1'b1;
    bus.i_cmd_nv_count = 8'd3;
    bus.i_nv_avail     = 1'b1;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("abort drain busy", bus.o_busy, 1);
    check("abort drain no issue", bus.o_dot_input_valid, 0);
    check("abort drain issued", issue_cnt, 3);
    @(posedge clk); #1;
    bus.i_abort = 1'b1;
    @(posedge clk); #1;
    bus.i_abort    = 1'b0;
    bus.i_nv_avail = 1'b0;
    @(negedge clk);
    check("abort idle busy", bus.o_busy, 0);
    check("abort idle cmd_ready", bus.o_cmd_ready, 1);
    check("abort no result", bus.o_result_valid, 0);
    check("abort acc cleared", bus.o_result_mantissa, 0);
    run_cmd("post-abort", mk(1, 777, 4, 0, 0, 0, 0, 0, 0, 777, 4, 0, 7, 0, 0, 0));

    // Asynchronous reset in the middle of issuing.
    @(posedge clk); #1;
    tbl_man[0] = 1; tbl_man[1] = 2; tbl_man[2] = 3; tbl_man[3] = 4;
    issue_cnt          = 0;
    bus.i_cmd_valid    = 1'b1;
    bus.i_cmd_nv_count = 8'd4;
    bus.i_nv_avail     = 1'b1;
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid-issue busy", bus.o_busy, 1);
    check("mid-issue nv_idx", bus.o_nv_idx, 1);
    #2 rst_n = 1'b0;
    #1 check_reset("mid-issue reset");
    @(posedge clk); #1;
    rst_n          = 1'b1;
    bus.i_nv_avail = 1'b0;
    run_cmd("post-reset", vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gfp8_nv_dot_sched.md
# gfp8_nv_dot_sched

Sequencer and accumulator for the GFP8 native-vector dot engine. It accepts a command to reduce N native vectors and issues them one per available cycle to the engine's `i_input_valid` strobe. It tracks the in-flight results through the engine's fixed pipeline latency and accumulates the returned GFP partials, mantissa and exponent, into one aligned result. It sits between the BCV/dispatch controller and the dot engine, and presents the final result through a valid/ready handshake.

## Interface
- `DOT_LATENCY`, default 5: cycles from an `o_dot_input_valid` pulse to the matching `i_dot_mantissa`/`i_dot_exponent`. Legal range 1..16.
- `NV_CNT_W`, default 8: width of the per-command NV count.
- `i_clk`  in  1  clock.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_cmd_valid`  in  1  command request.
- `o_cmd_ready`  out  1  high exactly when state is IDLE.
- `i_cmd_nv_count`  in  NV_CNT_W  number of NVs to reduce; 0 is legal.
- `i_nv_avail`  in  1  the operand buffer has NV `o_nv_idx` presented to the engine this cycle.
- `o_nv_idx`  out  NV_CNT_W  index of the next NV to issue.
- `o_dot_input_valid`  out  1  issue strobe to the engine.
- `i_dot_mantissa`  in  32 signed  engine result mantissa.
- `i_dot_exponent`  in  8 signed  engine result exponent.
- `i_abort`  in  1  synchronous flush.
- `o_result_valid`  out  1  final result held.
- `i_result_ready`  in  1  consumer accept.
- `o_result_mantissa`  out  32 signed  accumulated mantissa.
- `o_result_exponent`  out  8 signed  accumulated exponent.
- `o_sat`  out  1  a saturation occurred during this command; valid together with the result.
- `o_busy`  out  1  state is not IDLE.

## Operation
- **States:** IDLE, ISSUE, DRAIN, DONE.
- **IDLE:**
  - On `i_cmd_valid`, latch the count and clear the issue count, return count, accumulator, `o_sat` and the first-result flag.
  - Go to DONE if the count is 0, otherwise go to ISSUE.
- **ISSUE:**
  - `o_dot_input_valid` = `i_nv_avail`. This output is combinational from state, and it is the only combinational output besides `o_cmd_ready` and `o_busy`.
  - Each issue increments `o_nv_idx` and pushes a 1 into a DOT_LATENCY-deep valid-tag shift register. Non-issue cycles push 0.
  - When the last NV issues, go to DRAIN.
- **DRAIN:** no issues. Go to DONE on the cycle after the return count reaches the count.
- **Return handling:** runs in ISSUE and DRAIN whenever the tag register output is 1.
  - First return of a command: load the accumulator directly with the returned mantissa and exponent.
  - Later returns:
    - e_max = max(acc_exp, ret_exp).
    - Arithmetic right-shift each operand by e_max minus its own exponent. A shift greater than 31 makes that operand 0.
    - Form a 33-bit sum, then saturate to [-2^31, 2^31-1]. Saturation sets `o_sat` sticky.
    - acc_exp = e_max.
  - Accumulation is in arrival order, which equals issue order.
- **DONE:**
  - `o_result_valid` = 1. Result and `o_sat` are held stable.
  - On `i_result_ready`, go to IDLE.
  - A count-0 command yields mantissa 0, exponent 0, `o_sat` 0.
- **`i_abort`:** in any state it takes priority over every other transition.
  - Next state is IDLE; tags, counters and the accumulator are cleared; no result is produced.
  - In-flight engine outputs are ignored because the tags were cleared.
- **Simultaneous events:** a return arriving in the same cycle as the last issue is accumulated normally. A tag pushed and a tag popped in the same cycle both take effect.

## Timing
- **Reset:** state IDLE, and all registered outputs are 0: `o_result_valid`, `o_result_mantissa`, `o_result_exponent`, `o_sat`, `o_nv_idx`. `o_dot_input_valid` = 0 and `o_busy` = 0. `o_cmd_ready` = 1 from the IDLE state.
- **Command acceptance:** a command accepted at edge t means ISSUE is active in cycle t+1. The first `o_dot_input_valid` can occur in cycle t+1.
- **Return:** an issue in cycle c has its return sampled in cycle c+DOT_LATENCY, and the accumulator updates at the edge ending that cycle.
- **Result:** the last return in cycle r puts DONE with `o_result_valid` = 1 in cycle r+1.
- **Minimum command latency:** with N back-to-back issues and no gaps, acceptance to `o_result_valid` is N+DOT_LATENCY+1 cycles.
- **Handshake and back-to-back commands:** the result transfers on the edge where `o_result_valid` and `i_result_ready` are both 1. `o_cmd_ready` rises the following cycle, so commands are back-to-back with a one-cycle IDLE gap.
- **Stalls:** gaps in `i_nv_avail` stall issue only. Returns keep draining independently.

## Test plan
- **Single NV:** count=1; engine returns (man=100, exp=3) -> result (100, 3), `o_sat`=0, `o_result_valid` exactly DOT_LATENCY+2 cycles after acceptance.
- **Two NVs, exponent alignment:** count=2; returns (64, 5) then (64, 3) -> result (80, 5). Repeat with returns (8, 2) then (-7, 0) -> (-2 added) result (6, 2).
- **Saturation:** count=2; returns (0x7FFFFFF0, 0) then (0x20, 0) -> result (0x7FFFFFFF, 0), `o_sat`=1. Also, a return whose exponent is 40 below acc_exp contributes 0.
- **Avail gaps and backpressure:** count=4 with `i_nv_avail` toggling 1,0,0,1,1,0,1 -> exactly 4 issue pulses with `o_nv_idx` 0..3 and the sum correct. Hold `i_result_ready`=0 for 10 cycles -> result stable and `o_cmd_ready`=0 throughout.
- **Zero count:** count=0 -> `o_result_valid` in cycle t+1 with (0, 0) and no issue pulses.
- **Abort and reset mid-operation:** `i_abort` during DRAIN of count=3 -> IDLE next cycle. Late engine outputs do not corrupt a following count=1 command, which returns exactly its own value. Asserting `i_reset_n` low mid-ISSUE -> all outputs at reset values immediately.
